// File: rtl/mips_md_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op encodings, FSM states, default width.
package mips_md_pkg;

  localparam int unsigned MD_WIDTH = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    SIGN,
    DONE
  } md_state_e;

  function automatic logic op_is_signed(md_op_e op);
    return ~op[0];
  endfunction

  function automatic logic op_is_div(md_op_e op);
    return op[1];
  endfunction

endpackage

// File: rtl/md_iter_step.sv
// One combinational iteration: right-shifting shift-add multiply or left-shifting restoring divide.
module md_iter_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] acc_in,
  input  logic [WIDTH-1:0] opr_in,
  input  logic [WIDTH-1:0] mcand,
  output logic [WIDTH-1:0] acc_out,
  output logic [WIDTH-1:0] opr_out
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] trial;

  always_comb begin
    sum     = opr_in[0] ? ({1'b0, acc_in} + {1'b0, mcand}) : {1'b0, acc_in};
    rem_sh  = {acc_in, opr_in[WIDTH-1]};
    trial   = rem_sh - {1'b0, mcand};
    acc_out = '0;
    opr_out = '0;
    if (is_div) begin
      // A set borrow bit means the divisor did not fit: restore the shifted remainder.
      if (!trial[WIDTH]) begin
        acc_out = trial[WIDTH-1:0];
        opr_out = {opr_in[WIDTH-2:0], 1'b1};
      end else begin
        acc_out = rem_sh[WIDTH-1:0];
        opr_out = {opr_in[WIDTH-2:0], 1'b0};
      end
    end else begin
      {acc_out, opr_out} = {sum, opr_in[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit for MULT/MULTU/DIV/DIVU plus MTHI/MTLO writes.
module mult_div_unit
  import mips_md_pkg::*;
#(
  parameter int unsigned WIDTH = MD_WIDTH,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wr_data,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  md_state_e        state_q;
  md_op_e           op_q;
  logic [WIDTH-1:0] acc_q, opr_q, mcand_q, hi_q, lo_q;
  logic [WIDTH-1:0] acc_step, opr_step;
  logic             rs_sign_q, rt_sign_q, div_zero_q;
  logic [CNT_W-1:0] cnt_q;

  logic             in_signed, rs_neg_in, rt_neg_in;
  logic [WIDTH-1:0] rs_mag, rt_mag;
  logic             rs_neg, signs_differ, div_by_zero, is_div;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0] quot_fix, rem_fix;

  assign in_signed = op_is_signed(md_op_e'(op));
  assign rs_neg_in = in_signed & rs_val[WIDTH-1];
  assign rt_neg_in = in_signed & rt_val[WIDTH-1];
  assign rs_mag    = rs_neg_in ? -rs_val : rs_val;
  assign rt_mag    = rt_neg_in ? -rt_val : rt_val;

  assign is_div       = op_is_div(op_q);
  assign rs_neg       = op_is_signed(op_q) & rs_sign_q;
  assign signs_differ = rs_neg ^ (op_is_signed(op_q) & rt_sign_q);
  assign div_by_zero  = (mcand_q == '0);
  assign prod         = {acc_q, opr_q};
  assign prod_fix     = signs_differ ? -prod : prod;
  // With a zero divisor the remainder path ends holding |rs|, so re-signing restores rs_val.
  assign quot_fix     = (signs_differ && !div_by_zero) ? -opr_q : opr_q;
  assign rem_fix      = rs_neg ? -acc_q : acc_q;

  md_iter_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .is_div (is_div),
    .acc_in (acc_q),
    .opr_in (opr_q),
    .mcand  (mcand_q),
    .acc_out(acc_step),
    .opr_out(opr_step)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      op_q       <= OP_MULT;
      acc_q      <= '0;
      opr_q      <= '0;
      mcand_q    <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      rs_sign_q  <= 1'b0;
      rt_sign_q  <= 1'b0;
      div_zero_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          div_zero_q <= 1'b0;
          if (start) begin
            state_q   <= CALC;
            op_q      <= md_op_e'(op);
            acc_q     <= '0;
            opr_q     <= rs_mag;
            mcand_q   <= rt_mag;
            rs_sign_q <= rs_val[WIDTH-1];
            rt_sign_q <= rt_val[WIDTH-1];
            cnt_q     <= '0;
          end else begin
            state_q <= IDLE;
            if (wr_hi) hi_q <= wr_data;
            if (wr_lo) lo_q <= wr_data;
          end
        end
        CALC: begin
          acc_q <= acc_step;
          opr_q <= opr_step;
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_q <= SIGN;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        SIGN: begin
          state_q <= DONE;
          if (is_div) begin
            lo_q       <= quot_fix;
            hi_q       <= rem_fix;
            div_zero_q <= div_by_zero;
          end else begin
            {hi_q, lo_q} <= prod_fix;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy     = (state_q == CALC) || (state_q == SIGN);
  assign done     = (state_q == DONE);
  assign div_zero = div_zero_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: scoreboard of expected HI/LO/div_zero popped on each done pulse.
module tb_mult_div_unit;

  localparam logic [1:0] MULT  = 2'b00;
  localparam logic [1:0] MULTU = 2'b01;
  localparam logic [1:0] DIV   = 2'b10;
  localparam logic [1:0] DIVU  = 2'b11;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] rs_val = '0;
  logic [31:0] rt_val = '0;
  logic        wr_hi = 1'b0;
  logic        wr_lo = 1'b0;
  logic [31:0] wr_data = '0;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  exp_t sb[$];
  int   n_pass = 0;
  int   n_total = 0;

  mult_div_unit #(
    .WIDTH(32),
    .CNT_W(6)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .rs_val  (rs_val),
    .rt_val  (rt_val),
    .wr_hi   (wr_hi),
    .wr_lo   (wr_lo),
    .wr_data (wr_data),
    .busy    (busy),
    .done    (done),
    .div_zero(div_zero),
    .hi      (hi),
    .lo      (lo)
  );

  always #5 clk = ~clk;

  function automatic void check(string tag, logic [63:0] obs, logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endfunction

  function automatic void push(logic [31:0] eh, logic [31:0] el, logic ez);
    exp_t e;
    e.hi = eh;
    e.lo = el;
    e.dz = ez;
    sb.push_back(e);
  endfunction

  // Compare each done pulse against the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset && done) begin
      if (sb.size() == 0) begin
        check("spurious_done", 64'(done), 64'(0));
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("done_hi", 64'(hi), 64'(e.hi));
        check("done_lo", 64'(lo), 64'(e.lo));
        check("done_div_zero", 64'(div_zero), 64'(e.dz));
      end
    end
  end

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    op = o;
    rs_val = a;
    rt_val = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Caller sits #1 after the start edge (or later); exp_lat counts edges still to go.
  task automatic wait_done(input string tag, input int exp_lat, output int nbusy);
    int lat;
    lat = -1;
    nbusy = busy ? 1 : 0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = k;
        break;
      end
      if (busy) nbusy++;
    end
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                        input logic ez);
    int nb;
    push(eh, el, ez);
    issue(o, a, b);
    wait_done(tag, 33, nb);
    @(negedge clk);
  endtask

  initial begin
    int nb;
    #12;
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_div_zero", 64'(div_zero), 64'(0));
    check("rst_hi", 64'(hi), 64'(0));
    check("rst_lo", 64'(lo), 64'(0));
    @(negedge clk);
    reset = 1'b1;

    // Latency and busy window on the widest unsigned product.
    push(32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    issue(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("multu_max", 33, nb);
    check("multu_max_busy_cycles", 64'(nb), 64'(33));
    @(negedge clk);

    run_op("mult_neg", MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    run_op("mult_min", MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b0);
    run_op("div_neg", DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op("divu_7_2", DIVU, 32'd7, 32'd2, 32'd1, 32'd3, 1'b0);
    run_op("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0);
    run_op("divu_zero", DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1);
    run_op("multu_after_dz", MULTU, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0);
    run_op("div_neg_zero", DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1);
    run_op("multu_2_3", MULTU, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0);

    // MTHI while idle.
    @(negedge clk);
    wr_hi = 1'b1;
    wr_data = 32'h0000_1234;
    @(posedge clk);
    #1;
    wr_hi = 1'b0;
    check("mthi_hi", 64'(hi), 64'h1234);
    check("mthi_lo_hold", 64'(lo), 64'd6);

    // MTLO and a second start while busy are both dropped.
    push(32'd0, 32'd12, 1'b0);
    issue(MULTU, 32'd3, 32'd4);
    @(negedge clk);
    wr_lo = 1'b1;
    wr_data = 32'h0000_AAAA;
    op = DIVU;
    rs_val = 32'd100;
    rt_val = 32'd7;
    start = 1'b1;
    @(posedge clk);
    #1;
    wr_lo = 1'b0;
    start = 1'b0;
    check("bw_busy", 64'(busy), 64'(1));
    check("bw_lo_hold", 64'(lo), 64'd6);
    check("bw_hi_hold", 64'(hi), 64'h1234);
    wait_done("bw", 32, nb);

    // Back-to-back: start on the DONE cycle, with an MTHI that must lose to the start.
    push(32'd0, 32'd1, 1'b0);
    op = MULT;
    rs_val = 32'hFFFF_FFFF;
    rt_val = 32'hFFFF_FFFF;
    wr_hi = 1'b1;
    wr_data = 32'h0000_DEAD;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wr_hi = 1'b0;
    check("b2b_busy", 64'(busy), 64'(1));
    check("b2b_hi_not_written", 64'(hi), 64'd0);
    wait_done("b2b", 33, nb);
    @(negedge clk);

    // Asynchronous reset mid-divide discards the operation.
    issue(DIVU, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    #2;
    check("pre_rst_busy", 64'(busy), 64'(1));
    reset = 1'b0;
    #1;
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_hi", 64'(hi), 64'(0));
    check("midrst_lo", 64'(lo), 64'(0));
    check("midrst_done", 64'(done), 64'(0));
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("post_rst_idle", 64'(busy), 64'(0));
    run_op("divu_100_7", DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);

    repeat (2) @(negedge clk);
    check("sb_drained", 64'(sb.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
